// File: rtl/attack_sequencer_if.sv
// Signal bundle between the attack sequencer and its surroundings:
// frame and button inputs, collision inputs, and the state and box outputs.
interface attack_sequencer_if;
  logic       frame_tick;
  logic       btn_attack;
  logic       btn_dir;
  logic       got_hit;
  logic       box_contact;
  logic [9:0] posx;
  logic [9:0] posy;
  logic [3:0] player_state;
  logic [9:0] hithurt_x1;
  logic [9:0] hithurt_x2;
  logic [9:0] hithurt_y1;
  logic [9:0] hithurt_y2;
  logic [9:0] dir_hithurt_x1;
  logic [9:0] dir_hithurt_x2;
  logic [9:0] dir_hithurt_y1;
  logic [9:0] dir_hithurt_y2;
  logic       busy;
  logic       hit_landed;

  modport master (
    output frame_tick, btn_attack, btn_dir, got_hit, box_contact, posx, posy,
    input  player_state, hithurt_x1, hithurt_x2, hithurt_y1, hithurt_y2,
           dir_hithurt_x1, dir_hithurt_x2, dir_hithurt_y1, dir_hithurt_y2,
           busy, hit_landed
  );

  modport slave (
    input  frame_tick, btn_attack, btn_dir, got_hit, box_contact, posx, posy,
    output player_state, hithurt_x1, hithurt_x2, hithurt_y1, hithurt_y2,
           dir_hithurt_x1, dir_hithurt_x2, dir_hithurt_y1, dir_hithurt_y2,
           busy, hit_landed
  );
endinterface

// File: rtl/attack_sequencer.sv
// Frame-timed fighter attack sequencer: basic and directional attack chains,
// hitstun, one-hit-per-attack detection, and registered hit/hurt boxes.
module attack_sequencer #(
  parameter int unsigned B_START = 5,
  parameter int unsigned B_ACT   = 2,
  parameter int unsigned B_REC   = 16,
  parameter int unsigned D_START = 4,
  parameter int unsigned D_ACT   = 3,
  parameter int unsigned D_REC   = 15,
  parameter int unsigned STUN    = 15,
  parameter int unsigned BX_OFF  = 32,
  parameter int unsigned BY_OFF  = 16,
  parameter int unsigned BW      = 24,
  parameter int unsigned BH      = 12,
  parameter int unsigned DX_OFF  = 8,
  parameter int unsigned DY_OFF  = 48,
  parameter int unsigned DW      = 40,
  parameter int unsigned DH      = 16
) (
  input logic               clk,
  input logic               rst,
  attack_sequencer_if.slave bus
);

  // Enum values double as the externally visible player_state codes.
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    B_STARTUP  = 4'd3,
    B_ACTIVE   = 4'd4,
    B_RECOVERY = 4'd5,
    D_STARTUP  = 4'd6,
    D_ACTIVE   = 4'd7,
    D_RECOVERY = 4'd8,
    HITSTUN    = 4'd9
  } state_t;

  state_t     state_reg, state_next;
  logic [4:0] cnt_reg, cnt_next;
  logic       pending_reg, pending_next;
  logic       pend_dir_reg, pend_dir_next;
  logic       consumed_reg, consumed_next;
  logic       hit_reg, hit_next;
  logic       busy_reg;
  logic       btn_a_reg, btn_d_reg;
  logic       rise_a, rise_d;

  assign rise_a = bus.btn_attack & ~btn_a_reg;
  assign rise_d = bus.btn_dir & ~btn_d_reg;

  function automatic logic [4:0] load(input int unsigned n);
    return 5'(n - 1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      pending_reg  <= 1'b0;
      pend_dir_reg <= 1'b0;
      consumed_reg <= 1'b0;
      hit_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      btn_a_reg    <= 1'b0;
      btn_d_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      pending_reg  <= pending_next;
      pend_dir_reg <= pend_dir_next;
      consumed_reg <= consumed_next;
      hit_reg      <= hit_next;
      busy_reg     <= (state_next != IDLE);
      btn_a_reg    <= bus.btn_attack;
      btn_d_reg    <= bus.btn_dir;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    pending_next  = pending_reg;
    pend_dir_next = pend_dir_reg;
    consumed_next = consumed_reg;
    hit_next      = 1'b0;

    // Hit detection looks at the current state only, so a contact on the
    // last ACTIVE cycle still counts even if the state leaves this cycle.
    if ((state_reg == B_ACTIVE || state_reg == D_ACTIVE) && bus.box_contact && !consumed_reg) begin
      hit_next      = 1'b1;
      consumed_next = 1'b1;
    end

    if (bus.got_hit) begin
      state_next   = HITSTUN;
      cnt_next     = load(STUN);
      pending_next = 1'b0;
    end else if (state_reg == IDLE) begin
      if (pending_reg) begin
        if (bus.frame_tick) begin
          state_next   = pend_dir_reg ? D_STARTUP : B_STARTUP;
          cnt_next     = pend_dir_reg ? load(D_START) : load(B_START);
          pending_next = 1'b0;
        end
      end else if (rise_a || rise_d) begin
        pending_next  = 1'b1;
        pend_dir_next = rise_d;
      end
    end else if (bus.frame_tick) begin
      if (cnt_reg != 5'd0) begin
        cnt_next = cnt_reg - 5'd1;
      end else begin
        case (state_reg)
          B_STARTUP: begin
            state_next    = B_ACTIVE;
            cnt_next      = load(B_ACT);
            consumed_next = 1'b0;
          end
          B_ACTIVE: begin
            state_next = B_RECOVERY;
            cnt_next   = load(B_REC);
          end
          D_STARTUP: begin
            state_next    = D_ACTIVE;
            cnt_next      = load(D_ACT);
            consumed_next = 1'b0;
          end
          D_ACTIVE: begin
            state_next = D_RECOVERY;
            cnt_next   = load(D_REC);
          end
          default: begin
            state_next = IDLE;
            cnt_next   = 5'd0;
          end
        endcase
      end
    end
  end

  assign bus.player_state = state_reg;
  assign bus.busy         = busy_reg;
  assign bus.hit_landed   = hit_reg;

  // Box 0 is the basic box, box 1 the directional box; sums wrap at 10 bits.
  for (genvar gi = 0; gi < 2; gi++) begin : g_box
    localparam logic [9:0] XO = 10'((gi == 0) ? BX_OFF : DX_OFF);
    localparam logic [9:0] YO = 10'((gi == 0) ? BY_OFF : DY_OFF);
    localparam logic [9:0] W  = 10'((gi == 0) ? BW : DW);
    localparam logic [9:0] H  = 10'((gi == 0) ? BH : DH);
    logic [9:0] x1_reg, x2_reg, y1_reg, y2_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        x1_reg <= '0;
        x2_reg <= '0;
        y1_reg <= '0;
        y2_reg <= '0;
      end else begin
        x1_reg <= bus.posx + XO;
        x2_reg <= bus.posx + XO + W;
        y1_reg <= bus.posy + YO;
        y2_reg <= bus.posy + YO + H;
      end
    end
  end

  assign bus.hithurt_x1     = g_box[0].x1_reg;
  assign bus.hithurt_x2     = g_box[0].x2_reg;
  assign bus.hithurt_y1     = g_box[0].y1_reg;
  assign bus.hithurt_y2     = g_box[0].y2_reg;
  assign bus.dir_hithurt_x1 = g_box[1].x1_reg;
  assign bus.dir_hithurt_x2 = g_box[1].x2_reg;
  assign bus.dir_hithurt_y1 = g_box[1].y1_reg;
  assign bus.dir_hithurt_y2 = g_box[1].y2_reg;

endmodule

// File: tb/tb_attack_sequencer.sv
// Self-checking bench for attack_sequencer: vector table, directed corner
// sequences, then randomized stimulus against a phase-level reference model.
module tb_attack_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  attack_sequencer_if bus ();

  attack_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_model = 1'b0;

  // Reference model: attack described as (kind, phase, ticks left).
  // phase -1 = idle, 0..2 = startup/active/recovery, 3 = hitstun.
  int b_dur[3] = '{5, 2, 16};
  int d_dur[3] = '{4, 3, 15};
  int m_phase = -1;
  int m_kind  = 0;
  int m_left  = 0;
  bit m_pend = 0, m_pdir = 0, m_used = 0, m_pa = 0, m_pd = 0, m_hit = 0;
  int m_box[8];

  typedef struct {
    bit a; bit d; bit t; bit c;
    int st; bit bsy; bit hit;
  } vec_t;
  vec_t tbl[12];

  function automatic int dur(int k, int p);
    return (k != 0) ? d_dur[p] : b_dur[p];
  endfunction

  function automatic int m_code();
    if (m_phase < 0) return 0;
    if (m_phase == 3) return 9;
    return 3 + 3 * m_kind + m_phase;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit ra, rd;
    if (rst) begin
      m_phase = -1; m_left = 0; m_pend = 0; m_pdir = 0; m_used = 0;
      m_pa = 0; m_pd = 0; m_hit = 0;
      for (int i = 0; i < 8; i++) m_box[i] = 0;
      return;
    end
    ra = bus.btn_attack && !m_pa;
    rd = bus.btn_dir && !m_pd;
    m_pa = bus.btn_attack;
    m_pd = bus.btn_dir;
    m_hit = (m_phase == 1) && bus.box_contact && !m_used;
    if (m_hit) m_used = 1;
    if (bus.got_hit) begin
      m_phase = 3; m_left = 15; m_pend = 0;
    end else if (m_phase < 0) begin
      if (m_pend) begin
        if (bus.frame_tick) begin
          m_kind = int'(m_pdir); m_phase = 0; m_left = dur(m_kind, 0); m_pend = 0;
        end
      end else if (ra || rd) begin
        m_pend = 1; m_pdir = rd;
      end
    end else if (bus.frame_tick) begin
      m_left--;
      if (m_left == 0) begin
        if (m_phase >= 2) m_phase = -1;
        else begin
          m_phase++;
          m_left = dur(m_kind, m_phase);
          if (m_phase == 1) m_used = 0;
        end
      end
    end
    m_box[0] = (int'(bus.posx) + 32) % 1024;
    m_box[1] = (m_box[0] + 24) % 1024;
    m_box[2] = (int'(bus.posy) + 16) % 1024;
    m_box[3] = (m_box[2] + 12) % 1024;
    m_box[4] = (int'(bus.posx) + 8) % 1024;
    m_box[5] = (m_box[4] + 40) % 1024;
    m_box[6] = (int'(bus.posy) + 48) % 1024;
    m_box[7] = (m_box[6] + 16) % 1024;
  endtask

  task automatic check_model();
    int act[8];
    act = '{bus.hithurt_x1, bus.hithurt_x2, bus.hithurt_y1, bus.hithurt_y2,
            bus.dir_hithurt_x1, bus.dir_hithurt_x2, bus.dir_hithurt_y1, bus.dir_hithurt_y2};
    chk("rand_state", bus.player_state, m_code());
    chk("rand_busy", bus.busy, (m_phase >= 0) ? 1 : 0);
    chk("rand_hit", bus.hit_landed, m_hit ? 1 : 0);
    for (int i = 0; i < 8; i++) chk($sformatf("rand_box%0d", i), act[i], m_box[i]);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    if (cmp_model) check_model();
  endtask

  task automatic tick_once();
    bus.frame_tick = 1'b1;
    cycle();
    bus.frame_tick = 1'b0;
    cycle();
  endtask

  task automatic press(input bit a, input bit d);
    bus.btn_attack = a;
    bus.btn_dir    = d;
    cycle();
  endtask

  // Counts frame ticks spent in state 'code', bounded so a stuck DUT fails.
  task automatic count_ticks(input int code, input int exp, input string name);
    int n = 0;
    chk({name, "_busy"}, bus.busy, 1);
    while (bus.player_state == 4'(code) && n < 40) begin
      tick_once();
      n++;
    end
    chk(name, n, exp);
    $display("seq %s: state %0d lasted %0d ticks", name, code, n);
  endtask

  task automatic chk_boxes(input string name, input int e[8]);
    int act[8];
    act = '{bus.hithurt_x1, bus.hithurt_x2, bus.hithurt_y1, bus.hithurt_y2,
            bus.dir_hithurt_x1, bus.dir_hithurt_x2, bus.dir_hithurt_y1, bus.dir_hithurt_y2};
    for (int i = 0; i < 8; i++) chk($sformatf("%s_box%0d", name, i), act[i], e[i]);
    $display("boxes %s: %0d %0d %0d %0d / %0d %0d %0d %0d", name,
             act[0], act[1], act[2], act[3], act[4], act[5], act[6], act[7]);
  endtask

  initial begin
    int zero_boxes[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int pos_boxes[8]  = '{132, 156, 216, 228, 108, 148, 248, 264};
    int wrap_boxes[8] = '{8, 32, 12, 24, 1008, 24, 44, 60};

    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 0, 3, 1, 0};
    tbl[2]  = '{0, 0, 1, 1, 3, 1, 0};
    tbl[3]  = '{0, 0, 1, 0, 3, 1, 0};
    tbl[4]  = '{0, 0, 1, 0, 3, 1, 0};
    tbl[5]  = '{0, 0, 1, 0, 3, 1, 0};
    tbl[6]  = '{0, 0, 1, 1, 4, 1, 0};
    tbl[7]  = '{0, 0, 0, 1, 4, 1, 1};
    tbl[8]  = '{0, 0, 0, 1, 4, 1, 0};
    tbl[9]  = '{0, 0, 1, 1, 4, 1, 0};
    tbl[10] = '{0, 0, 1, 1, 5, 1, 0};
    tbl[11] = '{0, 0, 0, 1, 5, 1, 0};

    rst = 1'b1;
    bus.frame_tick = 0; bus.btn_attack = 0; bus.btn_dir = 0;
    bus.got_hit = 0; bus.box_contact = 0; bus.posx = 10'd100; bus.posy = 10'd200;
    cycle();
    cycle();
    chk("reset_state", bus.player_state, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_hit", bus.hit_landed, 0);
    chk_boxes("reset", zero_boxes);
    rst = 1'b0;
    cycle();
    chk_boxes("pos100_200", pos_boxes);

    // Basic attack with contact from startup through active.
    for (int i = 0; i < 12; i++) begin
      bus.btn_attack  = tbl[i].a;
      bus.btn_dir     = tbl[i].d;
      bus.frame_tick  = tbl[i].t;
      bus.box_contact = tbl[i].c;
      cycle();
      chk($sformatf("vec%0d_state", i), bus.player_state, tbl[i].st);
      chk($sformatf("vec%0d_busy", i), bus.busy, tbl[i].bsy);
      chk($sformatf("vec%0d_hit", i), bus.hit_landed, tbl[i].hit);
      $display("vec %0d: a=%0d d=%0d t=%0d c=%0d -> state=%0d busy=%0d hit=%0d",
               i, tbl[i].a, tbl[i].d, tbl[i].t, tbl[i].c,
               bus.player_state, bus.busy, bus.hit_landed);
    end
    bus.frame_tick = 0; bus.box_contact = 0;
    count_ticks(5, 16, "vec_recovery");
    chk("vec_end_state", bus.player_state, 0);
    chk("vec_end_busy", bus.busy, 0);

    // Full basic chain.
    press(1, 0);
    press(0, 0);
    tick_once();
    chk("b_entry", bus.player_state, 3);
    count_ticks(3, 5, "b_startup");
    count_ticks(4, 2, "b_active");
    count_ticks(5, 16, "b_recovery");
    chk("b_done", bus.player_state, 0);

    // Both buttons together: directional wins; holding them never retriggers.
    press(1, 1);
    tick_once();
    chk("d_entry", bus.player_state, 6);
    count_ticks(6, 4, "d_startup");
    count_ticks(7, 3, "d_active");
    count_ticks(8, 15, "d_recovery");
    for (int i = 0; i < 3; i++) tick_once();
    chk("d_held_no_retrigger", bus.player_state, 0);
    press(0, 0);

    // got_hit with frame_tick in D_ACTIVE, then a restart after 10 ticks.
    press(0, 1);
    press(0, 0);
    tick_once();
    count_ticks(6, 4, "stun_pre_startup");
    chk("stun_pre_active", bus.player_state, 7);
    bus.got_hit = 1; bus.frame_tick = 1;
    cycle();
    bus.got_hit = 0; bus.frame_tick = 0;
    chk("stun_entry", bus.player_state, 9);
    for (int i = 0; i < 10; i++) tick_once();
    chk("stun_after10", bus.player_state, 9);
    bus.got_hit = 1;
    cycle();
    bus.got_hit = 0;
    count_ticks(9, 15, "stun_restart");
    chk("stun_done", bus.player_state, 0);

    // Reset in the middle of B_RECOVERY with contact asserted.
    press(1, 0);
    press(0, 0);
    tick_once();
    count_ticks(3, 5, "rst_startup");
    count_ticks(4, 2, "rst_active");
    tick_once();
    tick_once();
    chk("rst_pre_state", bus.player_state, 5);
    rst = 1; bus.box_contact = 1;
    cycle();
    chk("rst_state", bus.player_state, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_hit", bus.hit_landed, 0);
    chk_boxes("rst_mid", zero_boxes);
    rst = 0;
    cycle();
    bus.box_contact = 0;
    chk("rst_post_hit", bus.hit_landed, 0);
    chk_boxes("rst_resume", pos_boxes);
    tick_once();
    chk("rst_pending_clear", bus.player_state, 0);
    press(1, 0);
    press(0, 0);
    tick_once();
    chk("rst_new_press", bus.player_state, 3);

    // Wrap-around of box sums.
    bus.posx = 10'd1000; bus.posy = 10'd1020;
    cycle();
    chk_boxes("wrap", wrap_boxes);

    // Randomized stimulus against the reference model.
    cmp_model = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      rst             = ($urandom_range(0, 399) == 0);
      bus.frame_tick  = ($urandom_range(0, 3) == 0);
      bus.got_hit     = ($urandom_range(0, 199) == 0);
      bus.box_contact = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 5) == 0) bus.btn_attack = ~bus.btn_attack;
      if ($urandom_range(0, 7) == 0) bus.btn_dir = ~bus.btn_dir;
      bus.posx = 10'($urandom_range(0, 1023));
      bus.posy = 10'($urandom_range(0, 1023));
      cycle();
      $display("rand %0d: rst=%0d t=%0d hit_in=%0d -> state=%0d busy=%0d hit=%0d",
               i, rst, bus.frame_tick, bus.got_hit,
               bus.player_state, bus.busy, bus.hit_landed);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
